// File: rtl/alu_cmd_sequencer_if.sv
// Bundle of command, ALU-drive and response signals for alu_cmd_sequencer.
// slave = the sequencer, master = its environment (sender, ALU, consumer).
interface alu_cmd_sequencer_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          cmd_valid;
  logic          cmd_ready;
  logic [3:0]    cmd_a;
  logic [3:0]    cmd_b;
  logic [2:0]    cmd_op;
  logic [3:0]    alu_a;
  logic [3:0]    alu_b;
  logic [2:0]    alu_op;
  logic [3:0]    alu_result;
  logic          alu_carry;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [3:0]    rsp_result;
  logic          rsp_carry;
  logic          rsp_zero;
  logic [CW-1:0] count;

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op,
    output cmd_ready,
    output alu_a, alu_b, alu_op,
    input  alu_result, alu_carry,
    output rsp_valid, rsp_result, rsp_carry, rsp_zero,
    input  rsp_ready,
    output count
  );

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op,
    input  cmd_ready,
    input  alu_a, alu_b, alu_op,
    output alu_result, alu_carry,
    input  rsp_valid, rsp_result, rsp_carry, rsp_zero,
    output rsp_ready,
    input  count
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Command FIFO feeding one external 4-bit ALU, one command at a time,
// with a registered, handshaked response carrying result/carry/zero.
module alu_cmd_sequencer #(
  parameter int DEPTH = 4
) (
  input logic           clk,
  input logic           rst,
  alu_cmd_sequencer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    HOLD
  } state_e;

  state_e        state_q, state_d;
  cmd_t          mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  cmd_t          alu_q, alu_d;
  logic          rv_q, rv_d;
  logic [3:0]    rr_q, rr_d;
  logic          rc_q, rc_d;
  logic          rz_q, rz_d;
  logic          push, pop;
  logic          ready;
  logic          arith;

  assign ready = (cnt_q != FULL);
  assign push  = bus.cmd_valid && ready;
  // Carry is only meaningful for add/sub; the ALU leaves it undefined otherwise
  assign arith = (alu_q.op == 3'b000) || (alu_q.op == 3'b001);

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    alu_d   = alu_q;
    rv_d    = rv_q;
    rr_d    = rr_q;
    rc_d    = rc_q;
    rz_d    = rz_q;
    unique case (state_q)
      IDLE: begin
        if (cnt_q != '0) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        rr_d    = bus.alu_result;
        rz_d    = (bus.alu_result == 4'd0);
        rc_d    = arith && bus.alu_carry;
        rv_d    = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        if (bus.rsp_ready) begin
          rv_d = 1'b0;
          if (cnt_q != '0) begin
            pop     = 1'b1;
            state_d = ISSUE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (pop) alu_d = mem_q[rptr_q];
  end

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= '{bus.cmd_a, bus.cmd_b, bus.cmd_op};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      alu_q   <= '0;
      rv_q    <= 1'b0;
      rr_q    <= 4'd0;
      rc_q    <= 1'b0;
      rz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      alu_q   <= alu_d;
      rv_q    <= rv_d;
      rr_q    <= rr_d;
      rc_q    <= rc_d;
      rz_q    <= rz_d;
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  assign bus.cmd_ready  = ready;
  assign bus.alu_a      = alu_q.a;
  assign bus.alu_b      = alu_q.b;
  assign bus.alu_op     = alu_q.op;
  assign bus.rsp_valid  = rv_q;
  assign bus.rsp_result = rr_q;
  assign bus.rsp_carry  = rc_q;
  assign bus.rsp_zero   = rz_q;
  assign bus.count      = cnt_q;
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer driving a behavioural ALU whose
// carry_out is deliberately 1 for logic/shift ops.
module tb_alu_cmd_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  alu_cmd_sequencer_if #(.DEPTH(4)) bus ();

  alu_cmd_sequencer #(.DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [4:0] alu_w;
  always_comb begin
    alu_w = 5'd0;
    case (bus.alu_op)
      3'b000: alu_w = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
      3'b001: alu_w = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
      3'b010: alu_w = {1'b1, bus.alu_a & bus.alu_b};
      3'b011: alu_w = {1'b1, bus.alu_a | bus.alu_b};
      3'b100: alu_w = {1'b1, bus.alu_a ^ bus.alu_b};
      3'b101: alu_w = {1'b1, ~bus.alu_a};
      3'b110: alu_w = {1'b1, bus.alu_a[2:0], 1'b0};
      default: alu_w = {1'b1, 1'b0, bus.alu_a[3:1]};
    endcase
  end
  assign bus.alu_result = alu_w[3:0];
  assign bus.alu_carry  = alu_w[4];

  logic [5:0] exp_q[$];
  int         xfer_q[$];

  task automatic chk(input string nm, input int got, input int exp);
    n_chk = n_chk + 1;
    if (got == exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0h want %0h", nm, got, exp);
  endtask

  logic       stalled = 1'b0;
  logic [5:0] prev;
  logic [5:0] cur;
  always @(negedge clk) begin
    if (rst) begin
      stalled = 1'b0;
    end else begin
      cur = {bus.rsp_result, bus.rsp_carry, bus.rsp_zero};
      if (stalled && bus.rsp_valid)
        chk("rsp_stable", int'(cur), int'(prev));
      if (bus.rsp_valid && bus.rsp_ready) begin
        xfer_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", int'(cur), 0);
        end else begin
          chk("rsp_data", int'(cur), int'(exp_q.pop_front()));
        end
      end
      stalled = bus.rsp_valid && !bus.rsp_ready;
      prev    = cur;
    end
  end

  task automatic push(input logic [3:0] a, input logic [3:0] b,
                      input logic [2:0] op, input logic [3:0] er,
                      input logic ec);
    bit ok = 0;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_op    = op;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin
        exp_q.push_back({er, ec, er == 4'd0});
        ok = 1;
      end
      @(posedge clk);
      #1;
    end
    bus.cmd_valid = 1'b0;
    if (!ok) chk("push_timeout", 0, 1);
  endtask

  task automatic drain();
    bit ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) ok = 1;
    end
    chk("drain_done", int'(ok), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic lat_chk(input string nm);
    @(negedge clk);
    chk({nm, "_e0"}, int'(bus.rsp_valid), 0);
    @(negedge clk);
    chk({nm, "_e1"}, int'(bus.rsp_valid), 0);
    @(negedge clk);
    chk({nm, "_e2"}, int'(bus.rsp_valid), 1);
  endtask

  bit done6 = 0;

  initial begin
    bus.cmd_valid = 1'b1;
    bus.cmd_a     = 4'd7;
    bus.cmd_b     = 4'd7;
    bus.cmd_op    = 3'b000;
    bus.rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst           = 1'b0;
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    chk("rst_count", int'(bus.count), 0);
    chk("rst_cmd_ready", int'(bus.cmd_ready), 1);
    chk("rst_rsp_valid", int'(bus.rsp_valid), 0);
    chk("rst_rsp", int'({bus.rsp_result, bus.rsp_carry, bus.rsp_zero}), 0);
    chk("rst_alu", int'({bus.alu_a, bus.alu_b, bus.alu_op}), 0);
    @(posedge clk);
    #1;

    push(4'd5, 4'd3, 3'b000, 4'b1000, 1'b0);
    lat_chk("lat_add");
    chk("alu_a_issued", int'(bus.alu_a), 5);
    drain();
    push(4'd5, 4'd3, 3'b001, 4'b0010, 1'b0);
    drain();

    push(4'd9, 4'd8, 3'b000, 4'b0001, 1'b1);
    push(4'd3, 4'd5, 3'b001, 4'b1110, 1'b1);
    push(4'd5, 4'd2, 3'b010, 4'b0000, 1'b0);
    push(4'd9, 4'd8, 3'b000, 4'b0001, 1'b1);
    push(4'd5, 4'd0, 3'b101, 4'b1010, 1'b0);
    drain();

    bus.rsp_ready = 1'b0;
    push(4'd1, 4'd1, 3'b000, 4'd2, 1'b0);
    push(4'd2, 4'd1, 3'b000, 4'd3, 1'b0);
    push(4'd3, 4'd1, 3'b000, 4'd4, 1'b0);
    push(4'd4, 4'd1, 3'b000, 4'd5, 1'b0);
    push(4'd5, 4'd1, 3'b000, 4'd6, 1'b0);
    @(negedge clk);
    chk("full_count", int'(bus.count), 4);
    chk("full_cmd_ready", int'(bus.cmd_ready), 0);
    chk("full_rsp_valid", int'(bus.rsp_valid), 1);
    fork
      begin
        push(4'd6, 4'd1, 3'b000, 4'd7, 1'b0);
        done6 = 1;
      end
    join_none
    repeat (3) @(negedge clk);
    chk("stall_count", int'(bus.count), 4);
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    chk("after_pulse_ready", int'(bus.cmd_ready), 1);
    for (int i = 0; i < 20 && !done6; i++) @(negedge clk);
    chk("sixth_accepted", int'(done6), 1);
    chk("refill_count", int'(bus.count), 4);
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b1;
    drain();

    xfer_q.delete();
    push(4'd1,  4'd1,  3'b000, 4'd2,  1'b0);
    push(4'd15, 4'd1,  3'b000, 4'd0,  1'b1);
    push(4'd0,  4'd1,  3'b001, 4'd15, 1'b1);
    push(4'd12, 4'd10, 3'b010, 4'd8,  1'b0);
    push(4'd12, 4'd10, 3'b011, 4'd14, 1'b0);
    push(4'd12, 4'd10, 3'b100, 4'd6,  1'b0);
    push(4'd9,  4'd0,  3'b110, 4'd2,  1'b0);
    push(4'd9,  4'd0,  3'b111, 4'd4,  1'b0);
    drain();
    chk("burst_count", xfer_q.size(), 8);
    for (int i = 1; i < xfer_q.size(); i++)
      chk("burst_spacing", xfer_q[i] - xfer_q[i-1], 2);

    bus.rsp_ready = 1'b0;
    push(4'd1, 4'd0, 3'b000, 4'd1, 1'b0);
    push(4'd2, 4'd0, 3'b000, 4'd2, 1'b0);
    push(4'd3, 4'd0, 3'b000, 4'd3, 1'b0);
    push(4'd4, 4'd0, 3'b000, 4'd4, 1'b0);
    @(negedge clk);
    chk("hold_count", int'(bus.count), 3);
    chk("hold_valid", int'(bus.rsp_valid), 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("mrst_count", int'(bus.count), 0);
    chk("mrst_valid", int'(bus.rsp_valid), 0);
    chk("mrst_alu", int'({bus.alu_a, bus.alu_b, bus.alu_op}), 0);
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b1;
    push(4'd7, 4'd1, 3'b000, 4'd8, 1'b0);
    lat_chk("lat_post_rst");
    drain();
    chk("final_count", int'(bus.count), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
